// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and the oversampling receiver.
//   uart_state_e        : 3-bit frame state encoding (idle/start/data/parity/stop)
//   OVERSAMPLE          : s_tick pulses per bit period
//   DBIT_MIN/DBIT_MAX   : legal data-bit count per frame
//   SB_TICK_MIN/MAX     : legal stop-period length in s_ticks
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;

  localparam int DBIT_MIN    = 5;
  localparam int DBIT_MAX    = 8;
  localparam int SB_TICK_MIN = 8;
  localparam int SB_TICK_MAX = 32;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: serialises din LSB first as start bit, DBIT data bits,
// optional parity bit and a stop period, paced by the 16x oversampling s_tick.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between the
// last data bit and the stop period (PARITY_ODD selects odd/even sense).
//
// Parameters
//   DBIT       : data bits per frame (5..8), taken from din[DBIT-1:0]
//   SB_TICK    : stop-period length in s_ticks (16/24/32 = 1/1.5/2 stop bits)
//   PARITY_ODD : 0 = even parity, 1 = odd parity (parity build only)
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   tx_start     : request to send din, accepted only in idle
//   s_tick       : one-clk pulse at 16x the baud rate
//   din          : byte to send, captured at acceptance
//   tx_done_tick : one-clk pulse in the cycle the final stop s_tick is sampled
//   busy         : high whenever a frame is in progress
//   tx           : registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       busy,
  output logic       tx
);

  // Elaboration-time guard against configurations the counters cannot hold.
  if (DBIT < DBIT_MIN || DBIT > DBIT_MAX ||
      SB_TICK < SB_TICK_MIN || SB_TICK > SB_TICK_MAX ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal DBIT/SB_TICK/PARITY_ODD configuration");
  end

  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  uart_state_e state;
  logic [4:0]  s;       // s_tick count within the current bit
  logic [2:0]  n;       // data bits already sent
  logic [7:0]  b;       // shift register, b[0] is the bit on the line
  logic        tx_reg;

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK  = 8'((1 << DBIT) - 1);
  localparam logic       PAR_SENSE  = 1'(PARITY_ODD);
  logic par_bit;        // parity of the captured byte, fixed for the frame
`endif

  // NOTE: every register below is written with non-blocking assignments so all
  // state updates see the pre-edge values of each other, exactly like hardware.
  // tx_reg is loaded with the level of the state being entered, so the pin
  // changes on the same edge as the state and never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      tx_reg  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          // Acceptance does not wait for s_tick; bit timing restarts here.
          if (tx_start) begin
            state   <= ST_START;
            s       <= '0;
            b       <= din;
            tx_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^(din & DATA_MASK)) ^ PAR_SENSE;
`endif
          end
        end

        ST_START: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              state  <= ST_DATA;
              s      <= '0;
              n      <= '0;
              tx_reg <= b[0];
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        ST_DATA: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              s <= '0;
              b <= b >> 1;
              n <= n + 3'd1;
              if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                state  <= ST_PARITY;
                tx_reg <= par_bit;
`else
                state  <= ST_STOP;
                tx_reg <= 1'b1;
`endif
              end else begin
                // Next line level is the bit that the shift brings into b[0].
                tx_reg <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              state  <= ST_STOP;
              s      <= '0;
              tx_reg <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (s_tick) begin
            if (s == STOP_LAST) begin
              state  <= ST_IDLE;
              s      <= '0;
              tx_reg <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          s      <= '0;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

  // Done is decoded from the current state so it coincides with the last tick.
  assign tx_done_tick = (state == ST_STOP) && s_tick && (s == STOP_LAST);
  assign busy         = (state != ST_IDLE);
  assign tx           = tx_reg;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Instance 0 is the default 8N1 build,
// instance 1 uses DBIT=7/SB_TICK=32; with UART_TX_PARITY_EN defined,
// instances 2 and 3 are even- and odd-parity 8-bit builds.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic [7:0] din;
  logic [3:0] start_v;
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .tx_start(start_v[0]), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_w[0]), .busy(busy_w[0]), .tx(tx_w[0])
  );

  uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .tx_start(start_v[1]), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_w[1]), .busy(busy_w[1]), .tx(tx_w[1])
  );

`ifdef UART_TX_PARITY_EN
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset(reset), .tx_start(start_v[2]), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_w[2]), .busy(busy_w[2]), .tx(tx_w[2])
  );

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) dut3 (
    .clk(clk), .reset(reset), .tx_start(start_v[3]), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_w[3]), .busy(busy_w[3]), .tx(tx_w[3])
  );
`else
  assign tx_w[3:2]   = 2'b11;
  assign busy_w[3:2] = 2'b00;
  assign done_w[3:2] = 2'b00;
`endif

  typedef struct {
    int         sel;          // which instance
    logic [7:0] din;
    int         div;          // s_tick every div clocks
    logic       tick_acc;     // s_tick level at the acceptance edge
    int         dbit;
    int         nbits;        // 16-tick bits before stop (start+data+parity)
    int         frame_ticks;  // hand-computed frame length in s_ticks
    logic [9:0] exp_line;     // expected line level per bit, index 0 = start
    logic [7:0] exp_data;     // byte a receiver should decode
    int         poke;         // cycle of a stray tx_start with din=0xFF, 0 = none
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Sends one frame on instance v.sel and compares the line cycle by cycle.
  // Cycle c counts clock edges after the acceptance edge; outputs are sampled
  // at the negedge before edge c, i.e. they show the state after edge c-1.
  task automatic run_frame(input int idx, input vec_t v, input logic hold);
    int         len, bitlen, k, line_bad, first_bad, done_cnt, done_at, tail_bad;
    logic       exp_tx, exp_busy;
    logic [7:0] dec;
    len       = v.frame_ticks * v.div;
    bitlen    = 16 * v.div;
    line_bad  = 0;
    first_bad = -1;
    done_cnt  = 0;
    done_at   = -1;
    tail_bad  = 0;
    dec       = 8'h00;

    @(negedge clk);
    check($sformatf("v%0d_pre_idle", idx), {31'd0, busy_w[v.sel]}, 32'd0);
    din            = v.din;
    start_v        = '0;
    start_v[v.sel] = 1'b1;
    s_tick         = v.tick_acc;
    @(posedge clk);

    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      start_v[v.sel] = hold | (c == v.poke);
      if (c == v.poke) din = 8'hFF;
      s_tick = ((c % v.div) == 0);
      k = (c - 1) / bitlen;
      if (c <= len) begin
        exp_tx   = (k < v.nbits) ? v.exp_line[k] : 1'b1;
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
      if (tx_w[v.sel] !== exp_tx || busy_w[v.sel] !== exp_busy) begin
        line_bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (k >= 1 && k <= v.dbit && ((c - 1) % bitlen) == bitlen / 2)
        dec[k-1] = tx_w[v.sel];
      #1;
      if (done_w[v.sel] === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end

    check($sformatf("v%0d_line_first_bad_cycle", idx), first_bad, -1);
    check($sformatf("v%0d_line_errs", idx), line_bad, 0);
    check($sformatf("v%0d_done_count", idx), done_cnt, 1);
    check($sformatf("v%0d_done_cycle", idx), done_at, len);
    check($sformatf("v%0d_data", idx), {24'd0, dec}, {24'd0, v.exp_data});

    if (!hold) begin
      start_v = '0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        s_tick = 1'b1;
        if (busy_w[v.sel] !== 1'b0 || tx_w[v.sel] !== 1'b1) tail_bad++;
      end
      check($sformatf("v%0d_idle_tail", idx), tail_bad, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_at, rst_bad;
    vec_t hv;

    reset   = 1'b1;
    s_tick  = 1'b0;
    din     = 8'h00;
    start_v = '0;

    // Reset values before any clock edge.
    #1;
    check("rst_tx",   {31'd0, tx_w[0]},   32'd1);
    check("rst_busy", {31'd0, busy_w[0]}, 32'd0);
    check("rst_done", {31'd0, done_w[0]}, 32'd0);
    check("rst_tx_b", {31'd0, tx_w[1]},   32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    //                sel din    div ta dbit nb  ticks line     data   poke
    vecs.push_back('{0, 8'hA5, 1, 0, 8, 9,  160, 10'h14A, 8'hA5, 0});
    vecs.push_back('{0, 8'h3C, 4, 1, 8, 9,  160, 10'h078, 8'h3C, 0});
    vecs.push_back('{0, 8'h00, 1, 0, 8, 9,  160, 10'h000, 8'h00, 53});
    vecs.push_back('{1, 8'h41, 1, 0, 7, 8,  160, 10'h082, 8'h41, 0});
    vecs.push_back('{0, 8'h80, 2, 0, 8, 9,  160, 10'h100, 8'h80, 0});
    vecs.push_back('{1, 8'hFF, 3, 0, 7, 8,  160, 10'h0FE, 8'h7F, 0});
`ifdef UART_TX_PARITY_EN
    vecs.push_back('{2, 8'h07, 1, 0, 8, 10, 176, 10'h20E, 8'h07, 0});
    vecs.push_back('{3, 8'h07, 1, 0, 8, 10, 176, 10'h00E, 8'h07, 0});
`endif

    foreach (vecs[i]) run_frame(i, vecs[i], 1'b0);

    // tx_start held high: ignored through the frame and at the done cycle,
    // accepted on the next edge.
    hv = '{0, 8'h5A, 1, 0, 8, 9, 160, 10'h0B4, 8'h5A, 0};
    run_frame(100, hv, 1'b1);
    @(negedge clk);
    check("b2b_start_tx",   {31'd0, tx_w[0]},   32'd0);
    check("b2b_start_busy", {31'd0, busy_w[0]}, 32'd1);
    start_v = '0;
    done_at = -1;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      s_tick = 1'b1;
      #1;
      if (done_w[0] === 1'b1) begin
        done_at = c;
        break;
      end
    end
    check("b2b_done_cycle", done_at, 160);
    @(negedge clk);
    check("b2b_end_busy", {31'd0, busy_w[0]}, 32'd0);

    // Reset in the middle of a frame while the line is low.
    @(negedge clk);
    din        = 8'h00;
    start_v[0] = 1'b1;
    s_tick     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v = '0;
    repeat (40) @(negedge clk);
    check("midrst_pre_tx", {31'd0, tx_w[0]}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx",   {31'd0, tx_w[0]},   32'd1);
    check("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    rst_bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) rst_bad++;
    end
    check("midrst_no_done", rst_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's oversampling receiver. It accepts a parallel byte through a single-cycle start handshake and serializes it LSB first on `tx`: one start bit, DBIT data bits, an optional parity bit, then a stop period. Bit timing comes from the shared 16x oversampling `s_tick` produced by the top-level baud generator. The block sits between the host/FIFO write side and the `tx` pin.

## Interface
- `DBIT`, 8: data bits per frame, legal range 5..8; uses `din[DBIT-1:0]`.
- `SB_TICK`, 16: stop-period length in `s_tick`s; 16/24/32 give 1/1.5/2 stop bits; legal range 8..32.
- `PARITY_ODD`, 0: parity sense (0 = even, 1 = odd); only used when `UART_TX_PARITY_EN` is defined.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_start`  input  1  request to send `din`; sampled every `clk` edge.
- `s_tick`  input  1  one-`clk` pulse at 16x the baud rate.
- `din`  input  8  byte to send; captured on acceptance.
- `tx_done_tick`  output  1  one-`clk` pulse at the end of the stop period.
- `busy`  output  1  high whenever state is not idle.
- `tx`  output  1  serial line, registered, idles high.

## Operation
- States: idle, start, data, parity (present only with the macro), stop.
- Registers: state, 5-bit tick counter `s`, 3-bit bit counter `n`, 8-bit shift register `b`, `tx_reg`.
- idle: `tx` = 1. If `tx_start` = 1, go to start with `s` = 0 and `b` = `din`. The capture is independent of `s_tick`.
- start: `tx` = 0. On each `s_tick`, increment `s`. At `s` == 15 with `s_tick`, go to data with `s` = 0 and `n` = 0.
- data: `tx` = `b[0]`. At `s` == 15 with `s_tick`: `s` = 0, `b` shifts right, `n` increments.
  - If `n` == DBIT-1 at that point, go to parity (if compiled in), otherwise go to stop.
- parity: `tx` = XOR of captured `din[DBIT-1:0]`, XORed with `PARITY_ODD`. After 16 ticks, go to stop with `s` = 0.
- stop: `tx` = 1. At `s` == SB_TICK-1 with `s_tick`, go to idle and pulse `tx_done_tick`.
- `tx_start` outside idle is ignored. There is no queuing, and `din` changes mid-frame have no effect.
- `tx_start` in the same cycle as `tx_done_tick` is ignored, because the state is still stop. A request held high is accepted on the next cycle.
- No `s_tick` means all counters hold and `tx` holds its level.

## Timing
- Reset values: state = idle, `s` = 0, `n` = 0, `b` = 0, `tx` = 1, `busy` = 0, `tx_done_tick` = 0.
- Reset mid-frame forces `tx` high asynchronously, aborts the frame, and produces no done pulse.
- `tx` is driven from `tx_reg`, the registered next-state output, so it is glitch-free.
- Acceptance happens at the edge where idle samples `tx_start` = 1. At that same edge `tx` falls and `busy` rises.
- Each start, data and parity bit lasts exactly 16 `s_tick`s. The stop period lasts SB_TICK `s_tick`s.
- Frame length is 16·(1+DBIT+P)+SB_TICK ticks, where P = 1 with parity and 0 without. The default 8N1 frame is 160 ticks.
- `tx_done_tick` is combinational from state and counters. It is high for one `clk`, in the cycle the final stop `s_tick` is sampled.
- `busy` falls at the following edge. The earliest next acceptance is one `clk` after `tx_done_tick`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The parity state exists and a parity bit is inserted between the last data bit and stop.
  - `PARITY_ODD` selects the parity sense.
- `UART_TX_PARITY_EN` undefined:
  - No parity state and no parity logic.
  - Data is followed directly by stop.
  - `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding localparams (idle/start/data/parity/stop, 3-bit);
  - `OVERSAMPLE` = 16;
  - the DBIT and SB_TICK legal-range limits.
- The receiver uses the same package.
- No sub-module. The block is a single FSM with its datapath. `s_tick` comes from the existing top-level baud tick generator, which is not instantiated here.

## Test plan
- Reset: assert `reset` mid-frame with `tx` = 0 → `tx` = 1 and `busy` = 0 immediately; after release, no `tx_done_tick`.
- 8N1 frame: `s_tick` every cycle, `din` = 0xA5, one-cycle `tx_start` → `tx` = 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles. `tx_done_tick` pulses on cycle 160 after acceptance.
- Tick gating: `s_tick` every 4th cycle, `din` = 0x3C → each bit lasts 64 `clk`; decoded byte is 0x3C.
- Ignored request and back-to-back:
  - Pulse `tx_start` with `din` = 0xFF during the data state of a 0x00 frame → the frame is all zeros, and no second frame is sent.
  - Hold `tx_start` high continuously → the second frame's start bit begins one `clk` after `tx_done_tick`.
- Parameters: DBIT = 7 and SB_TICK = 32, `din` = 0x41 → 7 data bits 1,0,0,0,0,0,1, then a 32-tick stop period.
- Parity (`UART_TX_PARITY_EN`, `PARITY_ODD` = 0), `din` = 0x07 → a parity bit of 1 after bit 7; with `PARITY_ODD` = 1 the parity bit is 0; frame is 176 ticks.
